// File: rtl/regfile_burst_reader.sv
// Register file of DEPTH clock-enabled words with a combinational random-read port
// and a burst engine that streams a contiguous, wrapping address range over valid/ready.
module regfile_burst_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    state_t            state_r, state_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] ptr_r, ptr_nxt_s, ptr_inc_s;
    logic [ADDR_W:0]   remaining_r, remaining_nxt_s, eff_s;
    logic [DATA_W-1:0] dout_r, dout_nxt_s;
    logic              dout_valid_r, dout_valid_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;

    // Address wraps naturally because DEPTH is a power of two; oversize bursts are clamped.
    assign ptr_inc_s = ptr_r + ADDR_W'(1);
    assign eff_s     = (count > DEPTH_C) ? DEPTH_C : count;
    assign rdata     = mem_r[raddr];

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Storage: writes accepted in every engine state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // State register together with the registered burst outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            remaining_r  <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            remaining_r  <= remaining_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    // Next-state and datapath: words are loaded from pre-edge storage contents.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        remaining_nxt_s = remaining_r;
        dout_nxt_s      = dout_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_nxt_s = FIN;
                    end else begin
                        ptr_nxt_s       = base;
                        remaining_nxt_s = eff_s;
                        dout_nxt_s      = mem_r[base];
                        state_nxt_s     = SEND;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (dout_ready) begin
                    if (remaining_r == ONE_C) begin
                        state_nxt_s = FIN;
                    end else begin
                        ptr_nxt_s       = ptr_inc_s;
                        dout_nxt_s      = mem_r[ptr_inc_s];
                        remaining_nxt_s = remaining_r - ONE_C;
                        state_nxt_s     = SEND;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so flags are registered alongside it.
    always_comb begin
        dout_valid_nxt_s = (state_nxt_s == SEND);
        busy_nxt_s       = (state_nxt_s == SEND);
        done_nxt_s       = (state_nxt_s == FIN);
    end

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader: expected burst words are queued when a burst
// is launched and popped at every observed valid/ready handshake.
module tb_regfile_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] rdata;
    logic        start;
    logic [2:0]  base;
    logic [3:0]  count;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int valid_cnt = 0;
    int start_cyc = 0;
    int vstart = 0;
    int d0 = 0;
    logic [15:0] exp_q[$];

    regfile_burst_reader #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .start(start), .base(base), .count(count),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Sample at the falling edge (handshake, done, exclusivity), then advance past the rising edge.
    task automatic step();
        logic [15:0] e;
        @(negedge clk);
        cyc_n++;
        if (dout_valid && dout_ready) begin
            chk("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_word", {16'h0000, dout}, {16'h0000, e});
            end
        end
        if (dout_valid) valid_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        chk("done_busy_excl", 32'(done & busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic start_burst(input logic [2:0] b, input logic [3:0] c, input logic rdy);
        vstart = valid_cnt;
        base = b; count = c; dout_ready = rdy; start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc_n;
    endtask

    task automatic wait_done(input int max_cyc);
        int d_before;
        d_before = done_cnt;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt != d_before) break;
            step();
        end
        chk("done_seen", 32'(done_cnt != d_before), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        start = 1'b0; base = '0; count = '0; dout_ready = 1'b0;

        // Reset and random read
        step(); step(); step();
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", {16'h0000, dout}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr = 3'(i);
            #1;
            chk("rst_rdata", {16'h0000, rdata}, 32'd0);
        end
        we = 1'b1; waddr = 3'd3; wdata = 16'h0001; raddr = 3'd3;
        #1;
        chk("no_bypass", {16'h0000, rdata}, 32'd0);
        step();
        we = 1'b0;
        #1;
        chk("rdata_after_write", {16'h0000, rdata}, 32'h0000_0001);

        for (int i = 0; i < 8; i++) write_word(3'(i), 16'hA000 + 16'(i));

        // Basic burst
        exp_q.push_back(16'hA002); exp_q.push_back(16'hA003); exp_q.push_back(16'hA004);
        start_burst(3'd2, 4'd3, 1'b1);
        chk("latency_valid", 32'(dout_valid), 32'd1);
        chk("latency_busy", 32'(busy), 32'd1);
        wait_done(20);
        chk("basic_done_time", 32'(done_cyc - start_cyc), 32'd4);
        chk("basic_valid_cnt", 32'(valid_cnt - vstart), 32'd3);
        chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Wrap and clamp
        exp_q.push_back(16'hA006); exp_q.push_back(16'hA007);
        for (int i = 0; i < 6; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_burst(3'd6, 4'd10, 1'b1);
        wait_done(30);
        chk("wrap_done_time", 32'(done_cyc - start_cyc), 32'd9);
        chk("wrap_valid_cnt", 32'(valid_cnt - vstart), 32'd8);
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure
        exp_q.push_back(16'hA000); exp_q.push_back(16'hA001);
        start_burst(3'd0, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_dout_stable", {16'h0000, dout}, 32'h0000_A000);
            chk("bp_valid", 32'(dout_valid), 32'd1);
            step();
        end
        dout_ready = 1'b1;
        wait_done(10);
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // count = 0
        start_burst(3'd4, 4'd0, 1'b1);
        wait_done(5);
        chk("zero_done_time", 32'(done_cyc - start_cyc), 32'd1);
        chk("zero_no_valid", 32'(valid_cnt - vstart), 32'd0);

        // start during SEND is ignored
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_burst(3'd0, 4'd4, 1'b1);
        base = 3'd5; count = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(20);
        d0 = done_cnt;
        step(); step(); step();
        chk("ignored_valid_cnt", 32'(valid_cnt - vstart), 32'd4);
        chk("ignored_no_done", 32'(done_cnt - d0), 32'd0);
        chk("ignored_q_empty", 32'(exp_q.size()), 32'd0);

        // Write to base on the start edge: old value streamed
        exp_q.push_back(16'hA001);
        we = 1'b1; waddr = 3'd1; wdata = 16'hBEEF;
        start_burst(3'd1, 4'd1, 1'b1);
        we = 1'b0;
        wait_done(10);
        chk("wbase_q_empty", 32'(exp_q.size()), 32'd0);
        raddr = 3'd1;
        #1;
        chk("wbase_stored", {16'h0000, rdata}, 32'h0000_BEEF);

        // Reset mid-burst
        for (int i = 2; i < 6; i++) exp_q.push_back(16'hA000 + 16'(i));
        start_burst(3'd2, 4'd4, 1'b1);
        step();
        chk("mid_second_word", {16'h0000, dout}, 32'h0000_A003);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            raddr = 3'(i);
            #1;
            chk("mid_rst_mem", {16'h0000, rdata}, 32'd0);
        end
        exp_q.delete();
        d0 = done_cnt;
        vstart = valid_cnt;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_no_valid", 32'(valid_cnt - vstart), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
